// File: rtl/ppu_pkg.sv
// ppu_pkg: shared state encoding and VRAM layout constants for the BG line renderer
package ppu_pkg;
  typedef enum logic [2:0] {IDLE, OAM, FETCH, COMMIT, HBLANK, VBLANK} state_t;
  localparam logic [12:0] MAP0_BASE = 13'h1800;
  localparam logic [12:0] MAP1_BASE = 13'h1C00;
  localparam logic [12:0] TILE_SIGNED_BASE = 13'h1000;
  localparam int LINE_PIXELS = 160;
  localparam int FETCH_TILES = 21;
endpackage

// File: rtl/ppu_bg_line_renderer_if.sv
// ppu_bg_line_renderer_if: VRAM read bus, data valid one cycle after vramRd
interface ppu_bg_line_renderer_if;
  logic [12:0] vramAddr;
  logic vramRd;
  logic [7:0] vramData;
  modport master (output vramAddr, vramRd, input vramData);
  modport slave (input vramAddr, vramRd, output vramData);
endinterface

// File: rtl/ppu_tile_decode.sv
// ppu_tile_decode: one tile row (lo/hi planes) through the BG palette to 8 dark bits, bit p = pixel p from the left
module ppu_tile_decode (
  input logic [7:0] lo,
  input logic [7:0] hi,
  input logic [7:0] bgp,
  input logic bgEn,
  output logic [7:0] dark
);
  for (genvar p = 0; p < 8; p++) begin : g_px
    logic [1:0] c;
    assign c = {hi[7-p], lo[7-p]};
    assign dark[p] = bgEn & bgp[{c, 1'b1}];
  end
endmodule

// File: rtl/ppu_bg_line_renderer.sv
// ppu_bg_line_renderer: DMG dot/line timing plus BG tile fetch into a 160-bit line buffer.
// Optional STAT_IRQ_EN adds statMode and vblankIrq outputs.
module ppu_bg_line_renderer
  import ppu_pkg::*;
#(
  parameter logic [8:0] DOTS_PER_LINE = 9'd456,
  parameter logic [8:0] OAM_DOTS = 9'd80,
  parameter logic [7:0] VISIBLE_LINES = 8'd144,
  parameter logic [7:0] TOTAL_LINES = 8'd154
) (
  input logic pixelClk,
  input logic nReset,
  input logic [7:0] lcdc,
  input logic [7:0] scx,
  input logic [7:0] scy,
  input logic [7:0] bgp,
  ppu_bg_line_renderer_if.master vram,
  output logic [7:0] LY,
  output logic [LINE_PIXELS-1:0] LineBuffer,
  output logic lineValid
`ifdef STAT_IRQ_EN
  ,
  output logic [1:0] statMode,
  output logic vblankIrq
`endif
);
  localparam logic [8:0] FETCH_LAST = OAM_DOTS + 9'(FETCH_TILES * 6) - 9'd1;
  state_t state, state_n;
  logic [8:0] dot, dot_n;
  logic [7:0] line, line_n;
  logic line_end;
  logic [4:0] tile, col;
  logic [2:0] phase;
  logic [7:0] scx_l, bgy, idx, lo;
  logic [LINE_PIXELS+7:0] work, work_n;
  logic [7:0] dark;
  logic [12:0] map_addr, data_addr;
  logic rd;
  logic unused_lcdc;
  assign unused_lcdc = ^{lcdc[6:5], lcdc[2:1]};
  always_comb begin
    line_end = dot == DOTS_PER_LINE - 9'd1;
    dot_n = line_end ? 9'd0 : dot + 9'd1;
    line_n = line_end ? (line == TOTAL_LINES - 8'd1 ? 8'd0 : line + 8'd1) : line;
    state_n = state;
    case (state)
      IDLE: state_n = OAM;
      OAM: if (dot == OAM_DOTS - 9'd1) state_n = FETCH;
      FETCH: if (dot == FETCH_LAST) state_n = COMMIT;
      COMMIT: state_n = HBLANK;
      HBLANK, VBLANK: if (line_end) state_n = line_n < VISIBLE_LINES ? OAM : VBLANK;
      default: state_n = IDLE;
    endcase
    if (state == IDLE || !lcdc[7]) begin
      dot_n = 9'd0;
      line_n = 8'd0;
    end
    if (!lcdc[7]) state_n = IDLE;
  end
  // Each tile: map addr, idx capture, lo addr, lo capture, hi addr, hi decode.
  assign col = scx_l[7:3] + tile;
  assign map_addr = (lcdc[3] ? MAP1_BASE : MAP0_BASE) + {3'b0, bgy[7:3], col};
  assign data_addr = (lcdc[4] ? {1'b0, idx, 4'b0} : TILE_SIGNED_BASE + {idx[7], idx, 4'b0})
                   + {9'b0, bgy[2:0], 1'b0};
  assign rd = state == FETCH && !phase[0];
  assign vram.vramRd = rd;
  assign vram.vramAddr = !rd ? 13'd0 : phase == 3'd0 ? map_addr : phase == 3'd4 ? data_addr + 13'd1 : data_addr;
  ppu_tile_decode u_dec (.lo(lo), .hi(vram.vramData), .bgp(bgp), .bgEn(lcdc[0]), .dark(dark));
  always_comb begin
    work_n = work;
    if (state == FETCH && phase == 3'd5) work_n[{tile, 3'b0} +: 8] = dark;
  end
  always_ff @(posedge pixelClk) begin
    if (!nReset) begin
      state <= IDLE;
      dot <= 9'd0;
      line <= 8'd0;
      LY <= 8'd0;
      LineBuffer <= '0;
      tile <= 5'd0;
      phase <= 3'd0;
      scx_l <= 8'd0;
      bgy <= 8'd0;
      idx <= 8'd0;
      lo <= 8'd0;
      work <= '0;
    end else begin
      state <= state_n;
      dot <= dot_n;
      line <= line_n;
      work <= work_n;
      if (!lcdc[7]) LY <= 8'd0;
      if (state == OAM && state_n == FETCH) begin
        scx_l <= scx;
        bgy <= line + scy;
        tile <= 5'd0;
        phase <= 3'd0;
      end
      if (state == FETCH) begin
        phase <= phase == 3'd5 ? 3'd0 : phase + 3'd1;
        tile <= phase == 3'd5 ? tile + 5'd1 : tile;
        idx <= phase == 3'd1 ? vram.vramData : idx;
        lo <= phase == 3'd3 ? vram.vramData : lo;
      end
      // Final tile lands in work_n this same edge, so commit reads it from there.
      if (state_n == COMMIT) begin
        LineBuffer <= work_n[scx_l[2:0] +: LINE_PIXELS];
        LY <= line;
      end
    end
  end
  assign lineValid = state == COMMIT;
`ifdef STAT_IRQ_EN
  assign statMode = state == VBLANK ? 2'd1 : state == OAM ? 2'd2 : state == FETCH ? 2'd3 : 2'd0;
  assign vblankIrq = state == VBLANK && line == VISIBLE_LINES && dot == 9'd0;
`endif
endmodule
